// File: rtl/alu_32bit.sv
// ---------------------------------------------------------------------------
// alu_32bit
//   Registered integer ALU for the EX stage of the MIPS datapath. Operands A
//   and B are combined according to the 4-bit ALUControl code, and the result
//   is captured on the rising edge of Clk (one cycle of latency). Zero marks a
//   zero result and is updated together with ALUResult.
//   Rst is synchronous and active-high; it clears the result, so Zero reads 1.
// ---------------------------------------------------------------------------
module alu_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    // Shift amount width: only the low log2(WIDTH) bits of B select the shift.
    localparam int SHW = $clog2(WIDTH);

    // Operation encoding produced by the ALU control unit.
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;

    logic             sub_sel_s;      // adder runs as subtractor (SUB/SLT/SLTU)
    logic [WIDTH-1:0] b_eff_s;        // B or its one's complement
    logic [WIDTH:0]   sum_ext_s;      // adder output including carry out
    logic [WIDTH-1:0] sum_s;          // A+B or A-B, modulo 2^WIDTH
    logic             carry_s;        // carry out of the adder
    logic             ovf_s;          // signed overflow of A-B
    logic             slt_s;          // signed less-than
    logic             sltu_s;         // unsigned less-than
    logic [SHW-1:0]   shamt_s;        // shift distance
    logic [WIDTH-1:0] next_result_s;  // value to be captured at the next edge
    logic [WIDTH-1:0] result_r;       // registered result
    logic             zero_r;         // registered zero flag

    // Decide whether the shared adder must subtract (compare ops reuse A-B).
    always_comb begin
        sub_sel_s = 1'b0;
        case (ALUControl)
            OP_SUB, OP_SLT, OP_SLTU: sub_sel_s = 1'b1;
            default:                 sub_sel_s = 1'b0;
        endcase
    end

    // Shared adder/subtractor plus compare flags derived from it.
    // Signed less-than corrects the sign of A-B with the overflow bit, so the
    // comparison stays right when the subtraction overflows. Unsigned
    // less-than is a borrow, i.e. no carry out of A + ~B + 1.
    always_comb begin
        b_eff_s   = sub_sel_s ? ~B : B;
        sum_ext_s = {1'b0, A} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_sel_s};
        sum_s     = sum_ext_s[WIDTH-1:0];
        carry_s   = sum_ext_s[WIDTH];
        ovf_s     = (A[WIDTH-1] ^ B[WIDTH-1]) & (sum_s[WIDTH-1] ^ A[WIDTH-1]);
        slt_s     = sum_s[WIDTH-1] ^ ovf_s;
        sltu_s    = ~carry_s;
        shamt_s   = B[SHW-1:0];
    end

    // Result selection; unused codes give 0 so no X can reach the register.
    always_comb begin
        next_result_s = {WIDTH{1'b0}};
        case (ALUControl)
            OP_AND:  next_result_s = A & B;
            OP_OR:   next_result_s = A | B;
            OP_ADD:  next_result_s = sum_s;
            OP_XOR:  next_result_s = A ^ B;
            OP_SLL:  next_result_s = A << shamt_s;
            OP_SRL:  next_result_s = A >> shamt_s;
            OP_SUB:  next_result_s = sum_s;
            OP_SLT:  next_result_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU: next_result_s = {{(WIDTH-1){1'b0}}, sltu_s};
            OP_SRA:  next_result_s = $unsigned($signed(A) >>> shamt_s);
            OP_NOR:  next_result_s = ~(A | B);
            OP_MUL:  next_result_s = A * B;
            default: next_result_s = {WIDTH{1'b0}};
        endcase
    end

    // Capture result and its zero flag together; reset overrides any op.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            result_r <= next_result_s;
            zero_r   <= (next_result_s == {WIDTH{1'b0}});
        end
    end

    assign ALUResult = result_r;
    assign Zero      = zero_r;

endmodule

// File: tb/tb_alu_32bit.sv
// ---------------------------------------------------------------------------
// tb_alu_32bit
//   Scoreboard bench for alu_32bit. A driver issues one operation per cycle
//   and pushes the reference result into a queue; a monitor pops one entry
//   per cycle after the DUT's capture edge and compares ALUResult and Zero.
// ---------------------------------------------------------------------------
module tb_alu_32bit;

    logic        Clk;
    logic        Rst;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        Zero;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rst;
    } exp_t;

    exp_t sb[$];
    int   n_compared = 0;
    int   n_mismatch = 0;

    alu_32bit #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: arithmetic on wide integers, shifts as power-of-two
    // multiply/divide, compares as plain relational tests.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic rst);
        logic [63:0] wide;
        logic [63:0] pow;
        logic [31:0] r;
        int          sh;
        sh   = int'(b % 32);
        pow  = 64'd1 << sh;
        r    = 32'd0;
        wide = 64'd0;
        if (rst) return 32'd0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin wide = {32'd0, a} + {32'd0, b}; r = wide[31:0]; end
            4'd3:  r = a ^ b;
            4'd4:  begin wide = {32'd0, a} * pow; r = wide[31:0]; end
            4'd5:  begin wide = {32'd0, a} / pow; r = wide[31:0]; end
            4'd6:  begin wide = {32'd0, a} + 64'h1_0000_0000 - {32'd0, b}; r = wide[31:0]; end
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = (a < b) ? 32'd1 : 32'd0;
            4'd9:  begin
                       if (a[31] == 1'b0) begin
                           wide = {32'd0, a} / pow;
                           r = wide[31:0];
                       end else begin
                           wide = {32'd0, ~a} / pow;
                           r = ~wide[31:0];
                       end
                   end
            4'd12: r = ~(a | b);
            4'd13: begin wide = {32'd0, a} * {32'd0, b}; r = wide[31:0]; end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Drive one operation before the next rising edge and record its expectation.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rst);
        exp_t e;
        @(negedge Clk);
        ALUControl = op;
        A          = a;
        B          = b;
        Rst        = rst;
        e.res = model(op, a, b, rst);
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.rst = rst;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one result per cycle, sampled just after the capture edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_compared++;
                if (ALUResult !== e.res) begin
                    n_mismatch++;
                    $display("FAIL result op=%b a=%h b=%h rst=%b: got %h expected %h",
                             e.op, e.a, e.b, e.rst, ALUResult, e.res);
                end
                n_compared++;
                if (Zero !== (e.res == 32'd0)) begin
                    n_mismatch++;
                    $display("FAIL zero op=%b a=%h b=%h rst=%b: got %b expected %b",
                             e.op, e.a, e.b, e.rst, Zero, (e.res == 32'd0));
                end
            end
        end
    end

    // Stimulus: directed cases first, then randomized traffic.
    initial begin
        int wait_cycles;
        Rst        = 1'b1;
        ALUControl = 4'b0010;
        A          = 32'h1234_5678;
        B          = 32'h1111_1111;

        // Reset held for two edges with live operands.
        issue(4'b0010, 32'd15, 32'd10, 1'b1);
        issue(4'b0110, 32'd5,  32'd15, 1'b1);
        // ADD
        issue(4'b0010, 32'd0,  32'd0,  1'b0);
        issue(4'b0010, 32'd2,  32'd2,  1'b0);
        issue(4'b0010, 32'd15, 32'd10, 1'b0);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0);
        // SUB
        issue(4'b0110, 32'd2,  32'd2,  1'b0);
        issue(4'b0110, 32'd15, 32'd5,  1'b0);
        issue(4'b0110, 32'd5,  32'd15, 1'b0);
        // Logic
        issue(4'b0000, 32'd2,  32'd2,  1'b0);
        issue(4'b0000, 32'd15, 32'd0,  1'b0);
        issue(4'b0001, 32'd15, 32'd0,  1'b0);
        issue(4'b1100, 32'd0,  32'd0,  1'b0);
        issue(4'b0011, 32'hF0, 32'hFF, 1'b0);
        // Compares, including the overflow corner
        issue(4'b0111, 32'd0,  32'd15, 1'b0);
        issue(4'b0111, 32'd15, 32'd0,  1'b0);
        issue(4'b0111, 32'd0,  32'd0,  1'b0);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        issue(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        // Shifts, MUL, upper shift bits ignored
        issue(4'b0100, 32'd1, 32'd31, 1'b0);
        issue(4'b1001, 32'h8000_0000, 32'd4, 1'b0);
        issue(4'b0101, 32'h8000_0000, 32'd4, 1'b0);
        issue(4'b1101, 32'd7, 32'd6, 1'b0);
        issue(4'b0100, 32'd1, 32'd33, 1'b0);
        // Undefined code
        issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        // Reset in the middle of an ADD stream
        issue(4'b0010, 32'd3, 32'd4, 1'b0);
        issue(4'b0010, 32'd3, 32'd4, 1'b1);
        issue(4'b0010, 32'd3, 32'd4, 1'b0);

        for (int i = 0; i < 400; i++) begin
            issue(4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge Clk);
        Rst = 1'b0;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge Clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
